fetch_unit: RTL and testbench

Instruction fetch stage feeding the execute stage. It holds the program counter, presents `ins`/`pc` each cycle, and takes back `nextpc` to advance. It owns a 256-word instruction memory that is filled through a byte-serial valid/ready load port before the core is released to run. It also stops the core on a self-jump.

---
 rtl/fetch_unit_pkg.sv | 25 ++
 rtl/fetch_unit_if.sv | 15 +
 rtl/fetch_unit_inst_mem.sv | 30 +++
 rtl/fetch_unit.sv | 148 ++++++++++++++
 tb/tb_fetch_unit.sv | 302 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction fetch stage.
//   fetch_state_t    : fetch sequencer states
//   IMEM_AW_DEFAULT  : default instruction memory word-address width
//   NOP_INS_DEFAULT  : instruction presented while the core is not running
//   LANE_0..LANE_3   : byte-lane index within a word, big-endian order
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    RUN,
    HALT
  } fetch_state_t;

  localparam int unsigned IMEM_AW_DEFAULT = 8;

  // R-type add r0,r0,r0
  localparam logic [31:0] NOP_INS_DEFAULT = 32'h0000_0000;

  localparam logic [1:0] LANE_0 = 2'd0;  // bits [31:24]
  localparam logic [1:0] LANE_1 = 2'd1;  // bits [23:16]
  localparam logic [1:0] LANE_2 = 2'd2;  // bits [15:8]
  localparam logic [1:0] LANE_3 = 2'd3;  // bits [7:0]

endpackage

// File: rtl/fetch_unit_if.sv
// Byte-serial valid/ready load port used to fill the instruction memory.
//   ld_valid : byte valid (source)
//   ld_data  : byte value (source)
//   ld_last  : final byte of the image, qualified by ld_valid (source)
//   ld_ready : byte accepted when ld_valid & ld_ready (sink)
// master = image source, slave = fetch_unit.
interface fetch_unit_if;
  logic       ld_valid;
  logic [7:0] ld_data;
  logic       ld_last;
  logic       ld_ready;

  modport master (output ld_valid, output ld_data, output ld_last, input ld_ready);
  modport slave  (input ld_valid, input ld_data, input ld_last, output ld_ready);
endinterface

// File: rtl/fetch_unit_inst_mem.sv
// Instruction memory: 32-bit x 2^AW words.
//   clk   : write clock
//   wren  : write enable, active low (same polarity as the data memory)
//   waddr : write word address
//   wdata : write data
//   raddr : read word address
//   rdata : read data, asynchronous
// Contents are not initialised or cleared by reset.
module inst_mem
  import fetch_pkg::*;
#(
  parameter int unsigned AW = IMEM_AW_DEFAULT
) (
  input  logic          clk,
  input  logic          wren,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata
);

  logic [31:0] mem [2**AW];

  always_ff @(posedge clk) begin
    if (!wren) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage. Holds the PC, presents ins/pc to execute and
// advances to nextpc each RUN cycle; halts on a self-jump. Owns the
// instruction memory, filled big-endian through the byte-serial load port.
//   clk, rst    : clock, synchronous active-high reset
//   load_start  : enter LOAD (honoured in IDLE or HALT)
//   ld          : load byte port (valid/data/last in, ready out)
//   run         : level, 1 = execute, 0 = pause
//   nextpc      : next PC from execute
//   ins, pc     : instruction and PC to execute
//   running     : state == RUN
//   halted      : state == HALT
//   load_done   : one-cycle pulse on the first IDLE cycle after LOAD
//   load_words  : words written by the most recent load
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned IMEM_AW  = IMEM_AW_DEFAULT,
  parameter logic [31:0] PC_RESET = 32'd0,
  parameter logic [31:0] NOP_INS  = NOP_INS_DEFAULT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load_start,
  fetch_unit_if.slave        ld,
  input  logic               run,
  input  logic [31:0]        nextpc,
  output logic [31:0]        ins,
  output logic [31:0]        pc,
  output logic               running,
  output logic               halted,
  output logic               load_done,
  output logic [IMEM_AW:0]   load_words
);

  fetch_state_t         state;
  logic [1:0]           lane;
  logic [IMEM_AW-1:0]   waddr;
  logic [23:0]          hold;      // bytes already accepted for the current word, left-aligned
  logic                 ld_ready_q;

  logic                 accept;
  logic                 wr;
  logic                 done;
  logic [31:0]          word;
  logic [31:0]          rdata;

  assign ld.ld_ready = ld_ready_q;
  assign accept      = ld.ld_valid & ld_ready_q;

  // Merge the incoming byte into its lane; lanes not yet received read as zero
  // so an ld_last mid-word writes a zero-padded partial word.
  always_comb begin
    word = '0;
    case (lane)
      LANE_0:  word = {ld.ld_data, 24'h0};
      LANE_1:  word = {hold[23:16], ld.ld_data, 16'h0};
      LANE_2:  word = {hold[23:8], ld.ld_data, 8'h0};
      default: word = {hold, ld.ld_data};
    endcase
  end

  assign wr   = accept & ((lane == LANE_3) | ld.ld_last);
  assign done = accept & (ld.ld_last | ((lane == LANE_3) & (waddr == '1)));

  inst_mem #(.AW(IMEM_AW)) u_inst_mem (
    .clk   (clk),
    .wren  (~wr),
    .waddr (waddr),
    .wdata (word),
    .raddr (pc[IMEM_AW-1:0]),
    .rdata (rdata)
  );

  assign ins = running ? rdata : NOP_INS;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      pc         <= PC_RESET;
      lane       <= '0;
      waddr      <= '0;
      hold       <= '0;
      ld_ready_q <= 1'b0;
      running    <= 1'b0;
      halted     <= 1'b0;
      load_done  <= 1'b0;
      load_words <= '0;
    end else begin
      load_done <= 1'b0;
      case (state)
        IDLE: begin
          if (load_start) begin
            state      <= LOAD;
            ld_ready_q <= 1'b1;
            lane       <= '0;
            waddr      <= '0;
            hold       <= '0;
          end else if (run) begin
            state   <= RUN;
            running <= 1'b1;
          end
        end
        LOAD: begin
          if (accept) begin
            lane <= lane + 2'd1;
            hold <= word[31:8];
            if (wr) begin
              waddr <= waddr + IMEM_AW'(1);
              hold  <= '0;
            end
            // Every exit coincides with a write, so the count includes this word.
            if (done) begin
              state      <= IDLE;
              ld_ready_q <= 1'b0;
              pc         <= PC_RESET;
              load_done  <= 1'b1;
              load_words <= (IMEM_AW+1)'(waddr) + (IMEM_AW+1)'(1);
            end
          end
        end
        RUN: begin
          if (!run) begin
            state   <= IDLE;
            running <= 1'b0;
          end else if (nextpc == pc) begin
            state   <= HALT;
            running <= 1'b0;
            halted  <= 1'b1;
          end else begin
            pc <= nextpc;
          end
        end
        HALT: begin
          if (load_start) begin
            state      <= LOAD;
            halted     <= 1'b0;
            ld_ready_q <= 1'b1;
            lane       <= '0;
            waddr      <= '0;
            hold       <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        load_start;
  logic        run;
  logic [31:0] nextpc;
  logic [31:0] ins;
  logic [31:0] pc;
  logic        running;
  logic        halted;
  logic        load_done;
  logic [8:0]  load_words;

  fetch_unit_if ldi ();

  fetch_unit #(
    .IMEM_AW  (8),
    .PC_RESET (32'd0),
    .NOP_INS  (NOP)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .load_start (load_start),
    .ld         (ldi),
    .run        (run),
    .nextpc     (nextpc),
    .ins        (ins),
    .pc         (pc),
    .running    (running),
    .halted     (halted),
    .load_done  (load_done),
    .load_words (load_words)
  );

  always #5 clk = ~clk;

  int unsigned total = 0;
  int unsigned bad   = 0;

  // Reference image: what the memory should hold, and which words are defined.
  logic [31:0] mem_m [256];
  bit          known [256];
  logic [31:0] pc_m;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h", tag, got, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_fetch(input string tag);
    check({tag, "_pc"}, pc, pc_m);
    if (known[pc_m[7:0]]) check({tag, "_ins"}, ins, mem_m[pc_m[7:0]]);
  endtask

  // Sends an image with random gaps while toggling inputs LOAD must ignore.
  task automatic do_load(input logic [7:0] bytes[$], input bit use_last, input bit with_run);
    int unsigned n  = bytes.size();
    int unsigned nw = (n + 3) / 4;
    logic [31:0] w;
    load_start = 1'b1;
    run        = with_run;
    tick();
    load_start = 1'b0;
    run        = 1'b0;
    check("ld_ready_up", ldi.ld_ready, 1);
    check("load_no_run", running, 0);
    check("load_ins_nop", ins, NOP);
    for (int unsigned i = 0; i < n; i++) begin
      while ($urandom_range(0, 3) == 0) begin
        ldi.ld_valid = 1'b0;
        ldi.ld_data  = 8'($urandom);
        ldi.ld_last  = 1'($urandom);
        run          = 1'($urandom);
        load_start   = 1'($urandom);
        nextpc       = $urandom;
        tick();
        check("ld_ready_gap", ldi.ld_ready, 1);
      end
      ldi.ld_valid = 1'b1;
      ldi.ld_data  = bytes[i];
      ldi.ld_last  = use_last && (i == n - 1);
      run          = 1'($urandom);
      load_start   = 1'($urandom);
      nextpc       = $urandom;
      tick();
      ldi.ld_valid = 1'b0;
      ldi.ld_last  = 1'b0;
      if (i != n - 1) begin
        check("ld_ready_mid", ldi.ld_ready, 1);
        check("no_done_mid", load_done, 0);
      end
    end
    run        = 1'b0;
    load_start = 1'b0;
    check("ld_ready_down", ldi.ld_ready, 0);
    check("load_done_pulse", load_done, 1);
    check("load_words", load_words, nw);
    check("load_pc_reset", pc, 32'd0);
    check("load_not_running", running, 0);
    check("load_not_halted", halted, 0);
    check("load_exit_nop", ins, NOP);
    for (int unsigned k = 0; k < nw; k++) begin
      w = '0;
      for (int unsigned b = 0; b < 4; b++)
        w = {w[23:0], ((4*k + b) < n) ? bytes[4*k + b] : 8'h00};
      mem_m[k] = w;
      known[k] = 1'b1;
    end
    pc_m = 32'd0;
    tick();
    check("load_done_once", load_done, 0);
  endtask

  task automatic start_run();
    run = 1'b1;
    tick();
    check("running_up", running, 1);
    check("not_halted", halted, 0);
    check_fetch("start");
  endtask

  task automatic step(input logic [31:0] np);
    nextpc = np;
    tick();
    pc_m = np;
    check("running_step", running, 1);
    check_fetch("step");
  endtask

  task automatic pause();
    run = 1'b0;
    tick();
    check("pause_running", running, 0);
    check("pause_ins_nop", ins, NOP);
    check("pause_pc_hold", pc, pc_m);
  endtask

  task automatic random_run(input int unsigned n, input int unsigned nw);
    logic [31:0] np;
    for (int unsigned i = 0; i < n; i++) begin
      case ($urandom_range(0, 2))
        0:       np = pc_m + 32'd1;
        1:       np = ($urandom & 32'hFFFF_FF00) | $urandom_range(0, nw - 1);
        default: np = $urandom_range(0, nw - 1);
      endcase
      if (np == pc_m) np = pc_m + 32'd1;
      step(np);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] q[$];
    rst          = 1'b1;
    load_start   = 1'b0;
    run          = 1'b0;
    nextpc       = '0;
    ldi.ld_valid = 1'b0;
    ldi.ld_data  = '0;
    ldi.ld_last  = 1'b0;
    for (int unsigned i = 0; i < 256; i++) known[i] = 1'b0;
    pc_m = 32'd0;
    repeat (2) tick();
    check("rst_pc", pc, 32'd0);
    check("rst_ins", ins, NOP);
    check("rst_ld_ready", ldi.ld_ready, 0);
    check("rst_running", running, 0);
    check("rst_halted", halted, 0);
    check("rst_load_done", load_done, 0);
    check("rst_load_words", load_words, 0);
    rst = 1'b0;

    // A byte offered outside LOAD must go nowhere.
    ldi.ld_valid = 1'b1;
    ldi.ld_data  = 8'h5A;
    ldi.ld_last  = 1'b1;
    tick();
    ldi.ld_valid = 1'b0;
    ldi.ld_last  = 1'b0;
    check("idle_ready", ldi.ld_ready, 0);
    check("idle_no_done", load_done, 0);
    check("idle_words", load_words, 0);

    q = '{8'h00, 8'h00, 8'h08, 8'h00, 8'h04, 8'h21, 8'h00, 8'h05};
    do_load(q, 1'b1, 1'b0);
    start_run();
    step(32'd1);
    pause();

    q = '{8'hAA, 8'hBB};
    do_load(q, 1'b1, 1'b0);
    start_run();
    check("partial_word", ins, 32'hAABB_0000);
    step(32'd1);
    check("word1_kept", ins, 32'h0421_0005);
    pause();

    q = {};
    for (int unsigned i = 0; i < 24 + $urandom_range(1, 3); i++) q.push_back(8'($urandom));
    do_load(q, 1'b1, 1'b0);
    start_run();
    for (int unsigned k = 0; k < 5; k++) step(pc_m + 32'd1);
    pause();
    check("paused_at_5", pc, 32'd5);
    start_run();
    random_run(40, 7);
    if (pc_m == 32'h0000_0103) step(32'd0);
    step(32'h0000_0103);
    check("wrap_ins", ins, mem_m[3]);

    if (pc_m != 32'd7) step(32'd7);
    nextpc = 32'd7;
    tick();
    check("halt_flag", halted, 1);
    check("halt_running", running, 0);
    check("halt_pc", pc, 32'd7);
    check("halt_ins", ins, NOP);
    for (int unsigned i = 0; i < 4; i++) begin
      run    = ~run;
      nextpc = $urandom;
      tick();
      check("halt_sticky", halted, 1);
      check("halt_pc_hold", pc, 32'd7);
    end
    run = 1'b0;

    // Full image with no ld_last: ends on the final word.
    q = {};
    for (int unsigned i = 0; i < 1024; i++) q.push_back(8'($urandom));
    do_load(q, 1'b0, 1'b0);
    start_run();
    random_run(100, 256);
    step(32'hFFFF_FFFF);
    step(32'h0000_00FF);

    rst = 1'b1;
    tick();
    rst = 1'b0;
    pc_m = 32'd0;
    check("rst_run_running", running, 0);
    check("rst_run_pc", pc, 32'd0);
    check("rst_run_ins", ins, NOP);

    // Reset after six bytes: word 0 written, word 1 never completed.
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    check("abort_ready_up", ldi.ld_ready, 1);
    for (int unsigned i = 0; i < 6; i++) begin
      ldi.ld_valid = 1'b1;
      ldi.ld_data  = 8'(8'h11 * (i + 1));
      tick();
    end
    ldi.ld_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    mem_m[0] = 32'h1122_3344;
    check("abort_ready", ldi.ld_ready, 0);
    check("abort_words", load_words, 0);
    check("abort_done", load_done, 0);
    start_run();
    check("abort_word0", ins, 32'h1122_3344);
    step(32'd1);
    pause();

    q = '{8'hC3, 8'h3C};
    do_load(q, 1'b1, 1'b0);
    start_run();
    check("restart_lane0", ins, 32'hC33C_0000);
    step(32'd1);
    pause();

    // load_start and run together in IDLE: LOAD wins.
    q = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A};
    do_load(q, 1'b1, 1'b1);
    start_run();
    step(32'd1);
    check("both_word1", ins, 32'h9A00_0000);
    pause();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
